// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared register-file datapath constants and types
// Defaults and the write-back entry layout used by reg_writeback_port.
package datapath_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - pending-write FIFO for the register write-back port
// Storage, wrapping pointers and occupancy; REG_WB_BYPASS_EN exposes contents for forwarding.
module wb_fifo
  import datapath_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
`ifdef REG_WB_BYPASS_EN
  ,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [ADDR_W-1:0] mem_addr [DEPTH],
  output logic [DATA_W-1:0] mem_data [DEPTH]
`endif
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !clear && !full;
  assign pop_ok  = pop && !clear && !empty;

  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign count     = cnt_q;

`ifdef REG_WB_BYPASS_EN
  assign rd_ptr   = rd_ptr_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
`endif

  // Payload needs no reset: only slots inside the occupied window are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/reg_writeback_port.sv
// rtl/reg_writeback_port.sv - register-file write side with pending-write queue
// Optional forwarding of pending writes to the read ports when REG_WB_BYPASS_EN is defined.
module reg_writeback_port
  import datapath_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              RegWrite,
  input  logic              flush,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fwd_reg1,
  input  logic [ADDR_W-1:0] fwd_reg2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic [CNT_W-1:0]  pending
);

  logic              full, empty, push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  count;
`ifdef REG_WB_BYPASS_EN
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
`endif

  // Non-writing beats and $zero targets are accepted but never queued.
  assign wb_ready = !full;
  assign push     = wb_valid && wb_ready && RegWrite &&
                    (wb_reg != ADDR_W'(REG_ZERO)) && !flush;
  assign pop      = !empty && !rf_stall && !flush;
  assign pending  = count;

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_addr (wb_reg),
    .push_data (wb_data),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef REG_WB_BYPASS_EN
    ,
    .rd_ptr    (rd_ptr),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= head_addr;
      rf_wdata <= head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef REG_WB_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest write) wins.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0] res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (r != ADDR_W'(REG_ZERO)) begin
      if (rf_we && rf_waddr == r) res = {1'b1, rf_wdata};
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PTR_W'(k);
        if (CNT_W'(k) < count && mem_addr[idx] == r) res = {1'b1, mem_data[idx]};
      end
    end
    return res;
  endfunction

  assign {fwd_hit1, fwd_data1} = lookup(fwd_reg1);
  assign {fwd_hit2, fwd_data2} = lookup(fwd_reg2);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_reg1, fwd_reg2};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_port.sv
// tb/tb_reg_writeback_port.sv - self-checking bench for reg_writeback_port
// Directed scenarios then random traffic against a queue-based reference model.
module tb_reg_writeback_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, RegWrite, flush, rf_stall;
  logic        wb_ready;
  logic [4:0]  wb_reg, fwd_reg1, fwd_reg2, rf_waddr;
  logic [31:0] wb_data, rf_wdata, fwd_data1, fwd_data2;
  logic        rf_we, fwd_hit1, fwd_hit2;
  logic [2:0]  pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  reg_writeback_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data), .RegWrite(RegWrite), .flush(flush),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1),
    .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  // One clock edge of the write-back rules applied to the pending queue.
  task automatic model_step();
    bit acc;
    ent_t e;
    acc = wb_valid && (q.size() < DEPTH);
    if (flush) begin
      q.delete();
      m_we = 1'b0;
    end else begin
      if (q.size() > 0 && !rf_stall) begin
        m_we = 1'b1; m_waddr = q[0].a; m_wdata = q[0].d;
        void'(q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (acc && RegWrite && wb_reg != 5'd0) begin
        e.a = wb_reg; e.d = wb_data;
        q.push_back(e);
      end
    end
  endtask

  task automatic model_fwd(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
`ifdef REG_WB_BYPASS_EN
    if (r != 5'd0) begin
      if (m_we && m_waddr == r) begin hit = 1'b1; d = m_wdata; end
      foreach (q[i]) if (q[i].a == r) begin hit = 1'b1; d = q[i].d; end
    end
`endif
  endtask

  task automatic cycle();
    logic h;
    logic [31:0] d;
    #1;
    chk("wb_ready", wb_ready, (q.size() < DEPTH));
    model_fwd(fwd_reg1, h, d);
    chk("fwd_hit1", fwd_hit1, h);
    chk("fwd_data1", fwd_data1, d);
    model_fwd(fwd_reg2, h, d);
    chk("fwd_hit2", fwd_hit2, h);
    chk("fwd_data2", fwd_data2, d);
    @(posedge clk);
    model_step();
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("pending", pending, q.size());
  endtask

  task automatic beat(input logic [4:0] r, input logic [31:0] d, input logic rw);
    wb_valid = 1'b1; wb_reg = r; wb_data = d; RegWrite = rw;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 0; RegWrite = 0; flush = 0; rf_stall = 0;
    wb_reg = 0; wb_data = 0; fwd_reg1 = 0; fwd_reg2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_pending", pending, 0);
    chk("reset_ready", wb_ready, 1);
    chk("reset_waddr", rf_waddr, 0);
    chk("reset_fwd_hit1", fwd_hit1, 0);
    rst = 1'b0;

    // Single beat: visible on the write port two edges after acceptance.
    beat(5'd5, 32'hDEADBEEF, 1'b1);
    cycle();
    wb_valid = 1'b0;
    chk("lat_not_yet", rf_we, 0);
    cycle();
    chk("lat_we", rf_we, 1);
    chk("lat_waddr", rf_waddr, 5);
    chk("lat_wdata", rf_wdata, 32'hDEADBEEF);
    cycle();

    // Dropped beats: $zero target and RegWrite=0.
    beat(5'd0, 32'h1111, 1'b1);
    cycle();
    chk("drop_zero_pending", pending, 0);
    beat(5'd9, 32'h2222, 1'b0);
    cycle();
    chk("drop_rw_pending", pending, 0);
    wb_valid = 1'b0;
    repeat (2) cycle();

    // Fill under stall, then drain in order at one per cycle.
    rf_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      beat(5'(i), 32'h100 + i, 1'b1);
      cycle();
      if (i == 4) chk("full_ready", wb_ready, 0);
    end
    wb_valid = 1'b0; rf_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk("drain_order", rf_waddr, i);
    end
    cycle();

    // Youngest pending write to the same register is forwarded.
    rf_stall = 1'b1; fwd_reg1 = 5'd7; fwd_reg2 = 5'd3;
    beat(5'd7, 32'd1, 1'b1); cycle();
    beat(5'd7, 32'd2, 1'b1); cycle();
    wb_valid = 1'b0;
    #1;
`ifdef REG_WB_BYPASS_EN
    chk("fwd_young_hit", fwd_hit1, 1);
    chk("fwd_young_data", fwd_data1, 2);
`else
    chk("fwd_off_hit", fwd_hit1, 0);
    chk("fwd_off_data", fwd_data1, 0);
`endif
    rf_stall = 1'b0;
    repeat (3) cycle();

    // Flush with two pending and a same-cycle beat.
    rf_stall = 1'b1;
    beat(5'd11, 32'hAA, 1'b1); cycle();
    beat(5'd12, 32'hBB, 1'b1); cycle();
    beat(5'd10, 32'hCC, 1'b1); flush = 1'b1;
    cycle();
    chk("flush_pending", pending, 0);
    chk("flush_we", rf_we, 0);
    wb_valid = 1'b0; flush = 1'b0; rf_stall = 1'b0;
    repeat (2) cycle();

    // Async reset in the middle of a drain with three still pending.
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin beat(5'(20 + i), 32'h500 + i, 1'b1); cycle(); end
    wb_valid = 1'b0; rf_stall = 1'b0;
    cycle();
    chk("pre_rst_pending", pending, 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_we", rf_we, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", wb_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_reg   = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      RegWrite = ($urandom_range(0, 7) != 0);
      rf_stall = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      fwd_reg1 = 5'($urandom_range(0, 7));
      fwd_reg2 = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
